// File: rtl/operand_queue.sv
// operand_queue: A/B operand select feeding a DEPTH-entry valid/ready FIFO.
// Define OPERAND_FWD_EN to forward write-back data into rs1/rs2 at push time.
module operand_queue #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int CNTW  = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] inRs1,
   input  logic [WIDTH-1:0] inBusA,
   input  logic [WIDTH-1:0] inPC,
   input  logic [WIDTH-1:0] inRs2,
   input  logic [WIDTH-1:0] inBusB,
   input  logic [WIDTH-1:0] inImm,
   input  logic [1:0]       Asel,
   input  logic [1:0]       Bsel,
`ifdef OPERAND_FWD_EN
   input  logic [4:0]       rs1_idx,
   input  logic [4:0]       rs2_idx,
   input  logic             wb_en,
   input  logic [4:0]       wb_idx,
   input  logic [WIDTH-1:0] wb_data,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Aout,
   output logic [WIDTH-1:0] Bout,
   output logic [CNTW-1:0]  count
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_a [DEPTH];
   logic [WIDTH-1:0] mem_b [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] rs1_val;
   logic [WIDTH-1:0] rs2_val;
   logic [WIDTH-1:0] a_nxt;
   logic [WIDTH-1:0] b_nxt;

`ifdef OPERAND_FWD_EN
   // x0 is never forwarded; it always reads zero from the regfile
   assign rs1_val = (wb_en && wb_idx == rs1_idx && wb_idx != 5'd0)
                    ? wb_data : inRs1;
   assign rs2_val = (wb_en && wb_idx == rs2_idx && wb_idx != 5'd0)
                    ? wb_data : inRs2;
`else
   assign rs1_val = inRs1;
   assign rs2_val = inRs2;
`endif

   always_comb begin
      a_nxt = '0;
      case (Asel)
         2'b00:   a_nxt = rs1_val;
         2'b01:   a_nxt = inBusA;
         2'b10:   a_nxt = inPC;
         default: a_nxt = '0;
      endcase
   end

   always_comb begin
      b_nxt = '0;
      case (Bsel)
         2'b00:   b_nxt = rs2_val;
         2'b01:   b_nxt = inBusB;
         2'b10:   b_nxt = inImm;
         default: b_nxt = WIDTH'(4);
      endcase
   end

   assign in_ready  = (count != CNTW'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign Aout      = mem_a[rd_ptr];
   assign Bout      = mem_b[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] <= '0;
            mem_b[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem_a[wr_ptr] <= a_nxt;
            mem_b[wr_ptr] <= b_nxt;
            wr_ptr        <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            count <= count + CNTW'(1);
         end else if (pop && !push) begin
            count <= count - CNTW'(1);
         end
      end
   end

endmodule

// File: tb/tb_operand_queue.sv
// tb_operand_queue: directed and random checks of operand_queue
// against a queue-based reference model.
module tb_operand_queue;

   localparam int W     = 32;
   localparam int DEPTH = 4;
   localparam int CNTW  = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
   } ent_t;

   logic            clk = 1'b0;
   logic            reset, flush, in_valid, out_ready;
   logic            in_ready, out_valid;
   logic [W-1:0]    inRs1, inBusA, inPC, inRs2, inBusB, inImm;
   logic [1:0]      Asel, Bsel;
   logic [W-1:0]    Aout, Bout;
   logic [CNTW-1:0] count;
`ifdef OPERAND_FWD_EN
   logic [4:0]      rs1_idx, rs2_idx, wb_idx;
   logic            wb_en;
   logic [W-1:0]    wb_data;
`endif

   ent_t mq[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   operand_queue #(.WIDTH(W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .inRs1(inRs1), .inBusA(inBusA), .inPC(inPC),
      .inRs2(inRs2), .inBusB(inBusB), .inImm(inImm),
      .Asel(Asel), .Bsel(Bsel),
`ifdef OPERAND_FWD_EN
      .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .wb_en(wb_en),
      .wb_idx(wb_idx), .wb_data(wb_data),
`endif
      .out_valid(out_valid), .out_ready(out_ready),
      .Aout(Aout), .Bout(Bout), .count(count)
   );

   // Reference: what the entry should hold if a push happens now
   function automatic ent_t calc_entry();
      ent_t e;
      logic [W-1:0] r1, r2;
      r1 = inRs1;
      r2 = inRs2;
`ifdef OPERAND_FWD_EN
      if (wb_en && wb_idx != 0 && wb_idx == rs1_idx) r1 = wb_data;
      if (wb_en && wb_idx != 0 && wb_idx == rs2_idx) r2 = wb_data;
`endif
      e.a = (Asel == 0) ? r1 : (Asel == 1) ? inBusA :
            (Asel == 2) ? inPC : 0;
      e.b = (Bsel == 0) ? r2 : (Bsel == 1) ? inBusB :
            (Bsel == 2) ? inImm : 4;
      return e;
   endfunction

   // Update the model from the current inputs, then advance one cycle
   task automatic tick();
      ent_t e;
      int   n;
      e = calc_entry();
      n = mq.size();
      if (reset || flush) begin
         mq.delete();
      end else begin
         if (out_ready && n > 0) mq.delete(0);
         if (in_valid && n < DEPTH) mq.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic rand_sources();
      inRs1  = $urandom; inBusA = $urandom; inPC  = $urandom;
      inRs2  = $urandom; inBusB = $urandom; inImm = $urandom;
   endtask

   task automatic idle();
      reset = 0; flush = 0; in_valid = 0; out_ready = 0;
      Asel = 0; Bsel = 0;
      rand_sources();
`ifdef OPERAND_FWD_EN
      rs1_idx = 0; rs2_idx = 0; wb_en = 0; wb_idx = 0; wb_data = 0;
`endif
   endtask

   task automatic do_reset();
      reset = 1; in_valid = $urandom_range(1); out_ready = 1;
      tick();
      idle();
   endtask

   task automatic test_reset();
      idle();
      do_reset();
      do_reset();
      checks++;
      if (count !== 0 || out_valid !== 0 || in_ready !== 1) begin
         errors++;
         $display("FAIL reset_ctl: count=%0d ov=%b ir=%b want 0 0 1",
                  count, out_valid, in_ready);
      end
      checks++;
      if (Aout !== 0 || Bout !== 0) begin
         errors++;
         $display("FAIL reset_data: A=%0d B=%0d want 0 0", Aout, Bout);
      end
   endtask

   task automatic test_single();
      Asel = 0; Bsel = 0; inRs1 = 35; inRs2 = 84; in_valid = 1;
      tick();
      idle();
      checks++;
      if (out_valid !== 1 || Aout !== 35 || Bout !== 84 || count !== 1) begin
         errors++;
         $display("FAIL single: ov=%b A=%0d B=%0d cnt=%0d want 1 35 84 1",
                  out_valid, Aout, Bout, count);
      end
      do_reset();
   endtask

   task automatic test_full();
      for (int k = 1; k <= 5; k++) begin
         Asel = 1; Bsel = 2; inBusA = k; inImm = 100 + k; in_valid = 1;
         tick();
         checks++;
         if (in_ready !== (k < DEPTH)) begin
            errors++;
            $display("FAIL full_ready k=%0d: got %b want %b",
                     k, in_ready, (k < DEPTH));
         end
      end
      idle();
      checks++;
      if (count !== DEPTH) begin
         errors++;
         $display("FAIL full_count: got %0d want %0d", count, DEPTH);
      end
      out_ready = 1;
      for (int i = 1; i <= DEPTH; i++) begin
         checks++;
         if (Aout !== i || Bout !== 100 + i) begin
            errors++;
            $display("FAIL drain %0d: A=%0d B=%0d want %0d %0d",
                     i, Aout, Bout, i, 100 + i);
         end
         tick();
      end
      checks++;
      if (count !== 0 || out_valid !== 0) begin
         errors++;
         $display("FAIL drain_end: cnt=%0d ov=%b want 0 0", count, out_valid);
      end
      idle();
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 2; k++) begin
         rand_sources(); in_valid = 1;
         tick();
      end
      for (int c = 0; c < 6; c++) begin
         rand_sources(); Asel = 0; Bsel = 1;
         in_valid = 1; out_ready = 1;
         checks++;
         if (Aout !== mq[0].a || Bout !== mq[0].b) begin
            errors++;
            $display("FAIL b2b_head c=%0d: A=%h B=%h want %h %h",
                     c, Aout, Bout, mq[0].a, mq[0].b);
         end
         tick();
         checks++;
         if (count !== 2) begin
            errors++;
            $display("FAIL b2b_count c=%0d: got %0d want 2", c, count);
         end
      end
      idle();
      do_reset();
   endtask

   task automatic test_const();
      Asel = 2; inPC = 52; Bsel = 3; in_valid = 1;
      tick();
      rand_sources(); Asel = 3; Bsel = 2; inImm = 12; in_valid = 1;
      tick();
      idle();
      checks++;
      if (Aout !== 52 || Bout !== 4) begin
         errors++;
         $display("FAIL const1: A=%0d B=%0d want 52 4", Aout, Bout);
      end
      out_ready = 1;
      tick();
      checks++;
      if (Aout !== 0 || Bout !== 12) begin
         errors++;
         $display("FAIL const2: A=%0d B=%0d want 0 12", Aout, Bout);
      end
      idle();
      do_reset();
   endtask

   task automatic test_flush();
      for (int k = 0; k < 3; k++) begin
         rand_sources(); in_valid = 1;
         tick();
      end
      checks++;
      if (count !== 3) begin
         errors++;
         $display("FAIL flush_pre: cnt=%0d want 3", count);
      end
      flush = 1; in_valid = 1; out_ready = 1;
      tick();
      idle();
      checks++;
      if (count !== 0 || out_valid !== 0 || in_ready !== 1) begin
         errors++;
         $display("FAIL flush: cnt=%0d ov=%b ir=%b want 0 0 1",
                  count, out_valid, in_ready);
      end
      for (int k = 0; k < 2; k++) begin
         rand_sources(); in_valid = 1;
         tick();
      end
      reset = 1; in_valid = 1;
      tick();
      idle();
      checks++;
      if (count !== 0 || out_valid !== 0 || in_ready !== 1 ||
          Aout !== 0 || Bout !== 0) begin
         errors++;
         $display("FAIL mid_reset: cnt=%0d ov=%b ir=%b A=%0d B=%0d",
                  count, out_valid, in_ready, Aout, Bout);
      end
   endtask

`ifdef OPERAND_FWD_EN
   task automatic test_fwd();
      Asel = 0; Bsel = 0; rs1_idx = 5; rs2_idx = 6;
      wb_en = 1; wb_idx = 5; wb_data = 99; inRs1 = 7; inRs2 = 8;
      in_valid = 1;
      tick();
      idle();
      checks++;
      if (Aout !== 99 || Bout !== 8) begin
         errors++;
         $display("FAIL fwd_hit: A=%0d B=%0d want 99 8", Aout, Bout);
      end
      do_reset();
      Asel = 0; Bsel = 0; rs1_idx = 0; rs2_idx = 0;
      wb_en = 1; wb_idx = 0; wb_data = 99; inRs1 = 7; inRs2 = 8;
      in_valid = 1;
      tick();
      idle();
      checks++;
      if (Aout !== 7 || Bout !== 8) begin
         errors++;
         $display("FAIL fwd_x0: A=%0d B=%0d want 7 8", Aout, Bout);
      end
      do_reset();
   endtask
`endif

   task automatic test_random();
      for (int c = 0; c < 500; c++) begin
         rand_sources();
         Asel      = 2'($urandom);
         Bsel      = 2'($urandom);
         in_valid  = $urandom_range(1);
         out_ready = ($urandom_range(2) == 0);
         flush     = ($urandom_range(31) == 0);
`ifdef OPERAND_FWD_EN
         rs1_idx = 5'($urandom_range(3)); rs2_idx = 5'($urandom_range(3));
         wb_idx  = 5'($urandom_range(3)); wb_en   = $urandom_range(1);
         wb_data = $urandom;
`endif
         tick();
         checks++;
         if (count !== CNTW'(mq.size()) ||
             out_valid !== (mq.size() != 0) ||
             in_ready !== (mq.size() != DEPTH)) begin
            errors++;
            $display("FAIL rnd_ctl c=%0d: cnt=%0d ov=%b ir=%b want cnt=%0d",
                     c, count, out_valid, in_ready, mq.size());
         end
         if (mq.size() != 0) begin
            checks++;
            if (Aout !== mq[0].a || Bout !== mq[0].b) begin
               errors++;
               $display("FAIL rnd_head c=%0d: A=%h B=%h want %h %h",
                        c, Aout, Bout, mq[0].a, mq[0].b);
            end
         end
      end
      idle();
   endtask

   initial begin
      idle();
      reset = 1;
      test_reset();
      test_single();
      test_full();
      test_back_to_back();
      test_const();
      test_flush();
`ifdef OPERAND_FWD_EN
      test_fwd();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
